// File: rtl/lives_pkg.sv
// Shared geometry constants, glyph indices and blink FSM state for the lives HUD.
// Pure declarations; no logic, no latency, no flow control.
package lives_pkg;

  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int NUM_GLYPHS = 6;
  localparam int LABEL_W    = GLYPH_W * NUM_GLYPHS;

  typedef enum logic [2:0] {
    GLYPH_L     = 3'd0,
    GLYPH_I     = 3'd1,
    GLYPH_V     = 3'd2,
    GLYPH_E     = 3'd3,
    GLYPH_S     = 3'd4,
    GLYPH_COLON = 3'd5
  } glyph_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } blink_state_t;

  function automatic logic [7:0] glyph_addr(input logic [2:0] glyph, input logic [3:0] row);
    return {1'b0, glyph, row};
  endfunction

endpackage

// File: rtl/lives_counter.sv
// Lives count, game_over flag and (with LIVES_BLINK_EN) the lost-life blink FSM.
// lives updates on the pulse edge; game_over follows one clock later.
// No backpressure: every pulse is acted on the edge it is seen.
module lives_counter
  import lives_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 5,
  parameter int BLINK_FRAMES = 48
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       life_lost,
  input  logic       add_life,
  input  logic       new_game,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       blink_on,
  output logic [2:0] blink_idx
);

  logic [2:0] lives_nxt;
  logic       dec_eff;

  always_comb begin
    lives_nxt = lives;
    dec_eff   = 1'b0;
    if (new_game) begin
      lives_nxt = 3'(START_LIVES);
    end else if (life_lost && add_life) begin
      lives_nxt = lives;
    end else if (life_lost) begin
      if (lives != 3'd0) begin
        lives_nxt = lives - 3'd1;
        dec_eff   = 1'b1;
      end
    end else if (add_life) begin
      if (lives < 3'(MAX_LIVES)) lives_nxt = lives + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lives     <= 3'(START_LIVES);
      game_over <= 1'b0;
    end else begin
      lives     <= lives_nxt;
      game_over <= (lives == 3'd0);
    end
  end

`ifdef LIVES_BLINK_EN
  blink_state_t state;
  logic [7:0]   frame_cnt;
  logic [2:0]   lost_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      lost_idx  <= 3'd0;
    end else if (dec_eff) begin
      // a fresh loss always restarts the blink on the newly lost slot
      state     <= BLINK;
      frame_cnt <= 8'd0;
      lost_idx  <= lives_nxt;
    end else if (state == BLINK) begin
      if (new_game || add_life) begin
        state <= IDLE;
      end else if (frame_start) begin
        if (frame_cnt == 8'(BLINK_FRAMES - 1)) state <= IDLE;
        else frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign blink_on  = (state == BLINK) && !frame_cnt[3];
  assign blink_idx = lost_idx;
`else
  logic unused_blink;
  assign unused_blink = frame_start ^ dec_eff;
  assign blink_on     = 1'b0;
  assign blink_idx    = 3'd0;
`endif

endmodule

// File: rtl/lives_hud_renderer.sv
// Draws the "LIVES:" label and one icon per remaining life; optional blink via LIVES_BLINK_EN.
// Latency: 2 clocks from DrawX/DrawY to text_on/icon_on.
// No backpressure: free-running pixel pipeline, never stalls.
module lives_hud_renderer
  import lives_pkg::*;
#(
  parameter int TEXT_X       = 16,
  parameter int TEXT_Y       = 8,
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 5,
  parameter int ICON_W       = 12,
  parameter int ICON_GAP     = 4,
  parameter int BLINK_FRAMES = 48
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       frame_start,
  input  logic       life_lost,
  input  logic       add_life,
  input  logic       new_game,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       text_on,
  output logic       icon_on,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam logic [9:0] TX      = 10'(TEXT_X);
  localparam logic [9:0] TY      = 10'(TEXT_Y);
  localparam logic [9:0] TX_END  = 10'(TEXT_X + LABEL_W - 1);
  localparam logic [9:0] TY_END  = 10'(TEXT_Y + GLYPH_H - 1);
  localparam logic [9:0] ICON_Y0 = 10'(TEXT_Y + 4);
  localparam logic [9:0] ICON_Y1 = 10'(TEXT_Y + 11);
  localparam int         ICON_X0    = TEXT_X + LABEL_W + ICON_GAP;
  localparam int         ICON_PITCH = ICON_W + ICON_GAP;

  logic [9:0] dx, dy;
  logic       in_text_d;
  logic       icon_hit_d;
  logic [2:0] icon_k_d;

  logic       in_text_q;
  logic [2:0] glyph_q;
  logic [3:0] row_q;
  logic [2:0] col_q;
  logic       icon_hit_q;
  logic [2:0] icon_k_q;

  logic       blink_on;
  logic [2:0] blink_idx;

  assign dx = DrawX - TX;
  assign dy = DrawY - TY;

  // compare raw coordinates so values left of/above the label never wrap into it
  assign in_text_d = (DrawX >= TX) && (DrawX <= TX_END) && (DrawY >= TY) && (DrawY <= TY_END);

  logic unused_coord;
  assign unused_coord = ^{dx[9:6], dy[9:4]};

  always_comb begin
    icon_hit_d = 1'b0;
    icon_k_d   = 3'd0;
    if (DrawY >= ICON_Y0 && DrawY <= ICON_Y1) begin
      for (int i = 0; i < MAX_LIVES; i++) begin
        if (DrawX >= 10'(ICON_X0 + i * ICON_PITCH) &&
            DrawX <= 10'(ICON_X0 + i * ICON_PITCH + ICON_W - 1)) begin
          icon_hit_d = 1'b1;
          icon_k_d   = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      in_text_q  <= 1'b0;
      glyph_q    <= 3'd0;
      row_q      <= 4'd0;
      col_q      <= 3'd0;
      icon_hit_q <= 1'b0;
      icon_k_q   <= 3'd0;
    end else begin
      in_text_q  <= in_text_d;
      glyph_q    <= dx[5:3];
      row_q      <= dy[3:0];
      col_q      <= dx[2:0];
      icon_hit_q <= icon_hit_d;
      icon_k_q   <= icon_k_d;
    end
  end

  assign rom_addr = in_text_q ? glyph_addr(glyph_q, row_q) : 8'd0;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      text_on <= 1'b0;
      icon_on <= 1'b0;
    end else begin
      text_on <= in_text_q & rom_data[3'd7 - col_q];
      icon_on <= icon_hit_q & ((icon_k_q < lives) | (blink_on & (icon_k_q == blink_idx)));
    end
  end

  lives_counter #(
    .START_LIVES  (START_LIVES),
    .MAX_LIVES    (MAX_LIVES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_lives_counter (
    .clk         (Clk),
    .reset_n     (Reset_n),
    .frame_start (frame_start),
    .life_lost   (life_lost),
    .add_life    (add_life),
    .new_game    (new_game),
    .lives       (lives),
    .game_over   (game_over),
    .blink_on    (blink_on),
    .blink_idx   (blink_idx)
  );

endmodule
